// File: rtl/uart_pkg.sv
// Shared UART transmitter types: FSM encoding and baud divisor helper.
// S_PARITY exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  // Truncating divide: the line runs slightly fast rather than slightly slow.
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Host-side byte handshake and line/status signals of the UART transmitter.
interface uart_tx_serializer_if #(
  parameter int FIFO_DEPTH = 16
);
  logic [7:0]                  tx_data;
  logic                        tx_valid;
  logic                        tx_ready;
  logic                        tx;
  logic                        tx_busy;
  logic                        tx_done;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, tx, tx_busy, tx_done, fifo_count
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, tx, tx_busy, tx_done, fifo_count
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Single-clock byte FIFO with read-ahead head; write and read take effect on the same edge.
// Writes are ignored while full, reads while empty; full/empty come from the registered count.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign do_wr   = wr_en & ~full;
  assign do_rd   = rd_en & ~empty;
  assign rd_data = mem[rd_ptr];

  // Pointers are exactly AW bits wide so they wrap on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// Buffered UART transmitter, 8N1 (8E1 with UART_TX_PARITY_EN); tx falls 2 edges after an accepted byte
// into an idle line, frames run back-to-back, and tx_ready drops only while the FIFO is full.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input logic                 clk,
  input logic                 rst,
  uart_tx_serializer_if.slave bus
);
  localparam int CPB   = clks_per_bit(CLK_FREQ, BAUD);
  localparam int CNT_W = (CPB > 2) ? $clog2(CPB) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;

  state_t           state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;
`ifdef UART_TX_PARITY_EN
  logic             parity;
`endif
  logic             tx_q;
  logic             busy_q;
  logic             done_q;
  logic [7:0]       head;
  logic             full;
  logic             empty;
  logic [CW-1:0]    count;
  logic             bit_end;
  logic             pop;

  assign bit_end = (baud_cnt == CNT_LAST);
  // Popping at the end of the stop bit is what removes the idle gap between frames.
  assign pop     = !empty && ((state == S_IDLE) || (state == S_STOP && bit_end));

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (bus.tx_valid),
    .wr_data (bus.tx_data),
    .rd_en   (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  assign bus.tx_ready   = ~full;
  assign bus.fifo_count = count;
  assign bus.tx         = tx_q;
  assign bus.tx_busy    = busy_q;
  assign bus.tx_done    = done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
`ifdef UART_TX_PARITY_EN
      parity    <= 1'b0;
`endif
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      // Line outputs follow the state by one edge, so tx_done lines up with the stop bit on tx.
      done_q   <= (state == S_STOP) && bit_end;
      busy_q   <= (state != S_IDLE) || !empty;
      baud_cnt <= (state == S_IDLE || bit_end) ? '0 : baud_cnt + CNT_W'(1);

      case (state)
        S_START:    tx_q <= 1'b0;
        S_DATA:     tx_q <= shift_reg[0];
`ifdef UART_TX_PARITY_EN
        S_PARITY:   tx_q <= parity;
`endif
        default:    tx_q <= 1'b1;
      endcase

      if (pop) begin
        shift_reg <= head;
        bit_idx   <= '0;
`ifdef UART_TX_PARITY_EN
        parity    <= ^head;
`endif
      end

      case (state)
        S_IDLE:  if (pop) state <= S_START;
        S_START: if (bit_end) state <= S_DATA;
        S_DATA: begin
          if (bit_end) begin
            shift_reg <= shift_reg >> 1;
            bit_idx   <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: if (bit_end) state <= S_STOP;
`endif
        S_STOP:  if (bit_end) state <= pop ? S_START : S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboarded bench for uart_tx_serializer: accepted bytes are queued as expectations and a
// line monitor decodes frames off tx for comparison.
module tb_uart_tx_serializer;
  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 100_000;
  localparam int DEPTH    = 16;
  localparam int CPB      = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS    = 11;
`else
  localparam int NBITS    = 10;
`endif
  localparam int FRAME    = NBITS * CPB;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       start_ok;
    logic       stop_ok;
    int         start_cyc;
  } frame_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  int   done_cnt = 0;
  int   done_cyc = 0;
  int   ready_viol = 0;
  int   full_seen = 0;
  int   maxc = 0;

  frame_t     rx_q[$];
  logic [7:0] exp_q[$];

  uart_tx_serializer_if #(.FIFO_DEPTH(DEPTH)) bus();

  uart_tx_serializer #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.tx_done === 1'b1) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (rst === 1'b0 && bus.tx_ready !== (bus.fifo_count != 5'd16)) ready_viol <= ready_viol + 1;
    if (bus.fifo_count == 5'd16 && bus.tx_ready === 1'b0) full_seen <= full_seen + 1;
    if (int'(bus.fifo_count) > maxc) maxc <= int'(bus.fifo_count);
  end

  // Line monitor: finds a start bit, samples every bit near its centre, drops frames cut by reset.
  initial begin : monitor
    frame_t f;
    logic   ab;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && bus.tx === 1'b0) begin
        f.start_cyc = cyc;
        ab = 1'b0;
        repeat (CPB/2 - 1) begin @(negedge clk); ab = ab | rst; end
        f.start_ok = (bus.tx === 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) begin @(negedge clk); ab = ab | rst; end
          f.data[i] = bus.tx;
        end
`ifdef UART_TX_PARITY_EN
        repeat (CPB) begin @(negedge clk); ab = ab | rst; end
        f.par = bus.tx;
`else
        f.par = 1'b0;
`endif
        repeat (CPB) begin @(negedge clk); ab = ab | rst; end
        f.stop_ok = (bus.tx === 1'b1);
        if (!ab) rx_q.push_back(f);
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // Called on a negedge; returns on the negedge right after the accepting edge.
  task automatic send(input logic [7:0] b, output int acc);
    int k = 0;
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    while (bus.tx_ready !== 1'b1 && k < 20000) begin @(negedge clk); k++; end
    if (k >= 20000) begin
      checks++;
      $display("FAIL send_timeout: tx_ready stuck at %b, wanted 1", bus.tx_ready);
    end
    @(negedge clk);
    exp_q.push_back(b);
    acc = cyc;
  endtask

  task automatic wait_rx(input int n, input int budget, output bit ok);
    int k = 0;
    while (rx_q.size() < n && k < budget) begin @(negedge clk); k++; end
    ok = (rx_q.size() >= n);
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int k = 0;
    while (bus.tx_busy !== 1'b0 && k < budget) begin @(negedge clk); k++; end
    ok = (bus.tx_busy === 1'b0);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.tx !== 1'b1) $display("FAIL reset_tx: got %b want 1", bus.tx); else passes++;
    checks++; if (bus.tx_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.tx_busy); else passes++;
    checks++; if (bus.tx_done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.tx_done); else passes++;
    checks++; if (bus.fifo_count !== 5'd0) $display("FAIL reset_count: got %0d want 0", bus.fifo_count); else passes++;
    checks++; if (bus.tx_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus.tx_ready); else passes++;
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    logic [7:0] b;
    logic       exp_tx;
    logic       busy_last, busy_after;
    int a, bad, nd, k;
    frame_t f;
    bit ok;
    b = 8'hA5;
    nd = done_cnt;
    bad = 0;
    busy_last = 1'b0;
    busy_after = 1'b1;
    send(b, a);
    bus.tx_valid = 1'b0;
    for (int o = 1; o <= FRAME + 3; o++) begin
      @(negedge clk);
      if (o < 2 || o >= FRAME + 2) exp_tx = 1'b1;
      else begin
        k = (o - 2) / CPB;
        if (k == 0)                   exp_tx = 1'b0;
        else if (k <= 8)              exp_tx = b[k-1];
        else if (k == 9 && NBITS == 11) exp_tx = ^b;
        else                          exp_tx = 1'b1;
      end
      if (bus.tx !== exp_tx) bad++;
      if (o == FRAME + 1) busy_last = bus.tx_busy;
      if (o == FRAME + 2) busy_after = bus.tx_busy;
    end
    checks++; if (bad != 0) $display("FAIL single_waveform: %0d cycles wrong, want 0", bad); else passes++;
    checks++; if (done_cnt - nd != 1) $display("FAIL single_done_count: got %0d want 1", done_cnt - nd); else passes++;
    checks++; if (done_cyc != a + FRAME + 1) $display("FAIL single_done_cycle: got %0d want %0d", done_cyc, a + FRAME + 1); else passes++;
    checks++; if (busy_last !== 1'b1) $display("FAIL single_busy_stop: got %b want 1", busy_last); else passes++;
    checks++; if (busy_after !== 1'b0) $display("FAIL single_busy_fall: got %b want 0", busy_after); else passes++;
    wait_rx(1, 2 * FRAME, ok);
    checks++;
    if (!ok) $display("FAIL single_frame: got 0 frames want 1");
    else begin
      f = rx_q.pop_front();
      b = exp_q.pop_front();
      if (f.data !== b || !f.start_ok || !f.stop_ok)
        $display("FAIL single_data: got %h (start %b stop %b) want %h", f.data, f.start_ok, f.stop_ok, b);
      else passes++;
    end
  endtask

  task automatic test_back_to_back();
    frame_t f[3];
    logic [7:0] e;
    int a, nd;
    bit ok, idle;
    nd = done_cnt;
    send(8'h00, a);
    send(8'hFF, a);
    send(8'h55, a);
    bus.tx_valid = 1'b0;
    wait_rx(3, 4 * FRAME, ok);
    checks++; if (!ok) $display("FAIL b2b_frames: got %0d want 3", rx_q.size()); else passes++;
    if (ok) begin
      for (int i = 0; i < 3; i++) begin
        f[i] = rx_q.pop_front();
        e = exp_q.pop_front();
        checks++;
        if (f[i].data !== e || !f[i].stop_ok) $display("FAIL b2b_data%0d: got %h want %h", i, f[i].data, e);
        else passes++;
      end
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (f[i].start_cyc - f[i-1].start_cyc != FRAME)
          $display("FAIL b2b_gap%0d: frame spacing %0d want %0d", i, f[i].start_cyc - f[i-1].start_cyc, FRAME);
        else passes++;
      end
    end
    wait_idle(2 * FRAME, idle);
    checks++; if (done_cnt - nd != 3) $display("FAIL b2b_done_count: got %0d want 3", done_cnt - nd); else passes++;
  endtask

  task automatic test_fifo_full();
    int a, bad;
    frame_t f;
    logic [7:0] e;
    bit ok, idle;
    for (int i = 0; i < 20; i++) send(8'(8'h21 + 13 * i), a);
    bus.tx_valid = 1'b0;
    checks++; if (maxc != 16) $display("FAIL full_max_count: got %0d want 16", maxc); else passes++;
    checks++; if (full_seen == 0) $display("FAIL full_ready_low: saw %0d full cycles with ready low, want >0", full_seen); else passes++;
    checks++; if (ready_viol != 0) $display("FAIL full_ready_vs_count: %0d cycles disagree, want 0", ready_viol); else passes++;
    wait_rx(20, 22 * FRAME, ok);
    checks++; if (!ok) $display("FAIL full_frames: got %0d want 20", rx_q.size()); else passes++;
    bad = 0;
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      f = rx_q.pop_front();
      e = exp_q.pop_front();
      if (f.data !== e || !f.stop_ok) bad++;
    end
    checks++; if (bad != 0) $display("FAIL full_order: %0d bytes wrong, want 0", bad); else passes++;
    wait_idle(2 * FRAME, idle);
  endtask

  task automatic test_push_pop_same_edge();
    int a0, a, bad;
    frame_t f;
    logic [7:0] e;
    bit ok, idle;
    send(8'h81, a0);
    for (int i = 1; i < 5; i++) send(8'(8'h81 + i), a);
    bus.tx_valid = 1'b0;
    while (cyc < a0 + FRAME) @(negedge clk);
    checks++; if (bus.fifo_count !== 5'd4) $display("FAIL pp_before: count %0d want 4", bus.fifo_count); else passes++;
    bus.tx_data  = 8'h86;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    exp_q.push_back(8'h86);
    bus.tx_valid = 1'b0;
    checks++; if (bus.fifo_count !== 5'd4) $display("FAIL pp_after: count %0d want 4", bus.fifo_count); else passes++;
    checks++; if (bus.tx_done !== 1'b1) $display("FAIL pp_stop_end: tx_done %b want 1", bus.tx_done); else passes++;
    wait_rx(6, 8 * FRAME, ok);
    checks++; if (!ok) $display("FAIL pp_frames: got %0d want 6", rx_q.size()); else passes++;
    bad = 0;
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      f = rx_q.pop_front();
      e = exp_q.pop_front();
      if (f.data !== e) bad++;
    end
    checks++; if (bad != 0) $display("FAIL pp_order: %0d bytes wrong, want 0", bad); else passes++;
    wait_idle(2 * FRAME, idle);
    repeat (2 * FRAME) @(negedge clk);
    checks++; if (rx_q.size() != 0) $display("FAIL pp_duplicate: %0d extra frames, want 0", rx_q.size()); else passes++;
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    frame_t f0, f1;
    int a;
    bit ok, idle;
    send(8'h07, a);
    send(8'h03, a);
    bus.tx_valid = 1'b0;
    wait_rx(2, 3 * FRAME, ok);
    checks++; if (!ok) $display("FAIL par_frames: got %0d want 2", rx_q.size()); else passes++;
    if (ok) begin
      f0 = rx_q.pop_front();
      f1 = rx_q.pop_front();
      void'(exp_q.pop_front());
      void'(exp_q.pop_front());
      checks++; if (f0.data !== 8'h07 || f0.par !== 1'b1) $display("FAIL par_first: got %h/%b want 07/1", f0.data, f0.par); else passes++;
      checks++; if (f1.data !== 8'h03 || f1.par !== 1'b0) $display("FAIL par_second: got %h/%b want 03/0", f1.data, f1.par); else passes++;
      checks++; if (f1.start_cyc - f0.start_cyc != 176) $display("FAIL par_length: got %0d want 176", f1.start_cyc - f0.start_cyc); else passes++;
    end
    wait_idle(2 * FRAME, idle);
  endtask
`endif

  task automatic test_reset_mid_frame();
    int a0, a, bad, nd;
    frame_t f;
    bit ok, idle;
    send(8'h61, a0);
    for (int i = 1; i < 6; i++) send(8'(8'h61 + i), a);
    bus.tx_valid = 1'b0;
    while (cyc < a0 + 2 + 3 * CPB + CPB / 2) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (bus.tx !== 1'b1) $display("FAIL rstmid_tx: got %b want 1", bus.tx); else passes++;
    checks++; if (bus.fifo_count !== 5'd0) $display("FAIL rstmid_count: got %0d want 0", bus.fifo_count); else passes++;
    checks++; if (bus.tx_busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", bus.tx_busy); else passes++;
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    nd = done_cnt;
    bad = 0;
    repeat (3 * FRAME) begin
      @(negedge clk);
      if (bus.tx !== 1'b1 || bus.tx_busy !== 1'b0) bad++;
    end
    checks++; if (bad != 0) $display("FAIL rstmid_idle: %0d active cycles, want 0", bad); else passes++;
    checks++; if (rx_q.size() != 0 || done_cnt != nd) $display("FAIL rstmid_no_frame: frames %0d done %0d, want 0 0", rx_q.size(), done_cnt - nd); else passes++;
    send(8'h3C, a);
    bus.tx_valid = 1'b0;
    wait_rx(1, 2 * FRAME, ok);
    checks++;
    if (!ok) $display("FAIL rstmid_resume: got 0 frames want 1");
    else begin
      f = rx_q.pop_front();
      if (f.data !== exp_q.pop_front()) $display("FAIL rstmid_resume: got %h want 3c", f.data);
      else passes++;
    end
    wait_idle(2 * FRAME, idle);
  endtask

  initial begin : main
    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_fifo_full();
    test_push_pop_same_edge();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
